// File: rtl/inst_encoder.sv
// inst_encoder: turns decoded instruction descriptors into MIPS words.
// Words are tagged with a running fetch address and queued in a FIFO.
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_kind,
  input  logic [5:0]                   in_opcode,
  input  logic [5:0]                   in_funct,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [31:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_addr,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] K_R     = 3'd0;
  localparam logic [2:0] K_SHIFT = 3'd1;
  localparam logic [2:0] K_I     = 3'd2;
  localparam logic [2:0] K_J     = 3'd3;
  localparam logic [2:0] K_LI    = 3'd4;
  localparam logic [2:0] K_NOP   = 3'd5;

  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_PREF  = 6'h33;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MOVZ = 6'h0A;
  localparam logic [5:0] F_MOVN = 6'h0B;
  localparam logic [5:0] F_SYNC = 6'h0F;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } state_t;

  state_t            r_state;
  logic [4:0]        r_li_rt;
  logic [15:0]       r_li_lo;
  logic [31:0]       r_addr;
  logic              r_err;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [31:0]       r_mem_inst [DEPTH];
  logic [31:0]       r_mem_addr [DEPTH];

  logic              w_not_full;
  logic              w_acc;
  logic              w_r_ok;
  logic              w_s_ok;
  logic              w_i_ok;
  logic              w_j_ok;
  logic              w_legal;
  logic              w_two;
  logic [31:0]       w_first;
  logic [15:0]       w_hi;
  logic [15:0]       w_lo;
  logic              w_push_first;
  logic              w_push_second;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_push_word;

  assign w_not_full = r_count < CW'(DEPTH);
  assign in_ready   = (r_state == S_IDLE) && w_not_full;
  assign w_acc      = in_valid && in_ready;
  assign w_hi       = in_imm[31:16];
  assign w_lo       = in_imm[15:0];

  // Legal function / opcode sets per descriptor kind
  always_comb begin
    w_r_ok = 1'b0;
    w_s_ok = 1'b0;
    w_i_ok = 1'b0;
    w_j_ok = 1'b0;
    case (in_funct)
      F_AND, F_OR, F_XOR, F_NOR, F_ADDU,
      F_SLLV, F_SRLV, F_SRAV, F_JR, F_SYNC,
      F_MOVZ, F_MOVN, F_MFHI, F_MTHI,
      F_MFLO, F_MTLO: w_r_ok = 1'b1;
      default:        w_r_ok = 1'b0;
    endcase
    case (in_funct)
      F_SLL, F_SRL, F_SRA: w_s_ok = 1'b1;
      default:             w_s_ok = 1'b0;
    endcase
    case (in_opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_ADDIU, OP_BEQ, OP_BNE, OP_BGTZ,
      OP_PREF: w_i_ok = 1'b1;
      default: w_i_ok = 1'b0;
    endcase
    case (in_opcode)
      OP_J, OP_JAL: w_j_ok = 1'b1;
      default:      w_j_ok = 1'b0;
    endcase
  end

  // Encode the first (or only) word of the accepted descriptor
  always_comb begin
    w_legal = 1'b0;
    w_two   = 1'b0;
    w_first = 32'h0000_0000;
    case (in_kind)
      K_R: begin
        w_legal = w_r_ok;
        w_first = {6'd0, in_rs, in_rt, in_rd, 5'd0, in_funct};
      end
      K_SHIFT: begin
        w_legal = w_s_ok;
        w_first = {6'd0, 5'd0, in_rt, in_rd, in_shamt, in_funct};
      end
      K_I: begin
        w_legal = w_i_ok;
        w_first = {in_opcode, in_rs, in_rt, w_lo};
      end
      K_J: begin
        w_legal = w_j_ok;
        w_first = {in_opcode, in_imm[25:0]};
      end
      K_LI: begin
        w_legal = 1'b1;
        if (w_hi == 16'h0000) begin
          w_first = {OP_ORI, 5'd0, in_rt, w_lo};
        end else begin
          w_first = {OP_LUI, 5'd0, in_rt, w_hi};
          w_two   = (w_lo != 16'h0000);
        end
      end
      K_NOP: begin
        w_legal = 1'b1;
        w_first = 32'h0000_0000;
      end
      default: begin
        w_legal = 1'b0;
        w_first = 32'h0000_0000;
      end
    endcase
  end

  assign w_push_first  = w_acc && w_legal;
  assign w_push_second = (r_state == S_SECOND) && w_not_full;
  assign w_push        = w_push_first || w_push_second;
  assign w_push_word   = w_push_second
                       ? {OP_ORI, r_li_rt, r_li_rt, r_li_lo}
                       : w_first;
  assign w_pop         = out_valid && out_ready;

  // LI sequencing: hold rt/lo until the trailing ORI is queued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_li_rt <= 5'd0;
      r_li_lo <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && (in_kind == K_LI) && w_two) begin
            r_state <= S_SECOND;
            r_li_rt <= in_rt;
            r_li_lo <= w_lo;
          end
        end
        S_SECOND: begin
          if (w_not_full) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address tag and illegal-descriptor pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_push) begin
        r_addr <= r_addr + 32'd4;
      end
    end
  end

  // FIFO storage; contents need no reset, pointers guard validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= w_push_word;
      r_mem_addr[r_wr_ptr] <= r_addr;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != '0);
  assign out_inst  = r_mem_inst[r_rd_ptr];
  assign out_addr  = r_mem_addr[r_rd_ptr];
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: random + directed descriptors against a word-level
// reference; expected words queued at accept, checked as they drain.
module tb_inst_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
  localparam int          CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [5:0]    in_opcode;
  logic [5:0]    in_funct;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_addr;
  logic          err;
  logic [CW-1:0] count;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } word_t;

  word_t q[$];
  word_t seen[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  bit rnd_done = 0;

  localparam logic [5:0] RF [16] = '{6'h24, 6'h25, 6'h26, 6'h27,
    6'h21, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0F, 6'h0A, 6'h0B,
    6'h10, 6'h11, 6'h12, 6'h13};
  localparam logic [5:0] SF [3] = '{6'h00, 6'h02, 6'h03};
  localparam logic [5:0] IO [9] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F,
    6'h09, 6'h04, 6'h05, 6'h07, 6'h33};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference encoder written from the field layouts
  function automatic void ref_enc(
    input  logic [2:0]  k,  input logic [5:0] op,
    input  logic [5:0]  fn, input logic [4:0] rs,
    input  logic [4:0]  rt, input logic [4:0] rd,
    input  logic [4:0]  sh, input logic [31:0] imm,
    output bit ok, output int n,
    output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] hi, lo;
    ok = 1'b0; n = 1; w0 = 32'd0; w1 = 32'd0;
    hi = imm >> 16;
    lo = imm & 32'hFFFF;
    case (k)
      3'd0: begin
        ok = fn inside {RF};
        w0 = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
      end
      3'd1: begin
        ok = fn inside {SF};
        w0 = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      end
      3'd2: begin
        ok = op inside {IO};
        w0 = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo;
      end
      3'd3: begin
        ok = (op == 6'd2) || (op == 6'd3);
        w0 = (32'(op) << 26) | (imm & 32'h03FF_FFFF);
      end
      3'd4: begin
        ok = 1'b1;
        if (hi == 0) begin
          w0 = (32'd13 << 26) | (32'(rt) << 16) | lo;
        end else begin
          w0 = (32'd15 << 26) | (32'(rt) << 16) | hi;
          if (lo != 0) begin
            n  = 2;
            w1 = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo;
          end
        end
      end
      3'd5: ok = 1'b1;
      default: ok = 1'b0;
    endcase
  endfunction

  int          m_count = 0;
  bit          m_pend  = 0;
  bit          m_err   = 0;
  logic [31:0] m_addr  = BASE;
  bit          r_ok;
  int          r_n;
  logic [31:0] r_w0, r_w1;
  int          r_push;
  bit          r_pop;

  // Model: occupancy, address, err and expected word stream
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_count = 0;
      m_pend  = 0;
      m_err   = 0;
      m_addr  = BASE;
    end else begin
      r_push = 0;
      r_pop  = out_ready && (m_count != 0);
      m_err  = 0;
      if (m_pend) begin
        if (m_count < DEPTH) begin
          r_push = 1;
          m_pend = 0;
        end
      end else if (in_valid && m_count < DEPTH) begin
        ref_enc(in_kind, in_opcode, in_funct, in_rs, in_rt, in_rd,
                in_shamt, in_imm, r_ok, r_n, r_w0, r_w1);
        if (!r_ok) begin
          m_err = 1;
        end else begin
          q.push_back('{r_w0, m_addr});
          m_addr += 32'd4;
          r_push = 1;
          if (r_n == 2) begin
            q.push_back('{r_w1, m_addr});
            m_addr += 32'd4;
            m_pend = 1;
          end
        end
      end
      m_count = m_count + r_push - (r_pop ? 1 : 0);
    end
  end

  // Per-cycle status checks
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), m_count);
      chk("in_ready", 32'(in_ready), 32'(!m_pend && m_count < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_count != 0));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // Monitor: head vs scoreboard, pop on handshake
  always @(negedge clk) begin
    if (chk_en && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h@%h expected none",
                 out_inst, out_addr);
      end else begin
        chk("out_inst", out_inst, q[0].inst);
        chk("out_addr", out_addr, q[0].addr);
        if (out_ready) begin
          seen.push_back('{out_inst, out_addr});
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [2:0] k, input logic [5:0] op,
                      input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [31:0] imm);
    int t;
    in_kind = k; in_opcode = op; in_funct = fn;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm;
    in_valid = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no accept expected accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rnd_send();
    logic [2:0]  k;
    logic [5:0]  op, fn;
    logic [31:0] imm;
    int          sel;
    sel = $urandom_range(0, 9);
    op  = 6'($urandom);
    fn  = 6'($urandom);
    imm = $urandom;
    case (sel)
      0, 1: begin
        k = 3'd0;
        if ($urandom_range(0, 9) != 0) fn = RF[$urandom_range(0, 15)];
      end
      2: begin
        k = 3'd1;
        if ($urandom_range(0, 9) != 0) fn = SF[$urandom_range(0, 2)];
      end
      3, 4: begin
        k = 3'd2;
        if ($urandom_range(0, 9) != 0) op = IO[$urandom_range(0, 8)];
      end
      5: begin
        k = 3'd3;
        if ($urandom_range(0, 9) != 0) op = 6'($urandom_range(2, 3));
      end
      6, 7: begin
        k = 3'd4;
        case ($urandom_range(0, 3))
          0: imm = imm & 32'h0000_FFFF;
          1: imm = imm & 32'hFFFF_0000;
          default: imm = imm;
        endcase
      end
      8: k = 3'd5;
      default: k = 3'($urandom_range(6, 7));
    endcase
    send(k, op, fn, 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), imm);
  endtask

  task automatic drain(input string nm);
    int t;
    out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk(nm, q.size(), 0);
  endtask

  logic [31:0] exp_inst [10];

  initial begin
    exp_inst = '{32'h3401_1234, 32'h3C02_1234, 32'h3442_5678,
                 32'h3402_5678, 32'h3C02_ABCD, 32'h0022_1821,
                 32'h0002_20C0, 32'h0800_0100, 32'h0000_0000,
                 32'h0000_0000};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 3'd0; in_opcode = 6'd0; in_funct = 6'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_shamt = 5'd0; in_imm = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodings, consumer always ready
    out_ready = 1'b1;
    seen.delete();
    send(3'd2, 6'h0D, 6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1234);
    send(3'd4, 6'd0, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5678);
    send(3'd4, 6'd0, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'h0000_5678);
    send(3'd4, 6'd0, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'hABCD_0000);
    send(3'd0, 6'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    send(3'd1, 6'd0, 6'h00, 5'd0, 5'd2, 5'd4, 5'd3, 32'd0);
    send(3'd3, 6'h02, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0100);
    send(3'd5, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(3'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    send(3'd5, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    drain("drain_directed");
    chk("directed_words", seen.size(), 10);
    for (int i = 0; i < 10 && i < seen.size(); i++) begin
      chk($sformatf("lit_inst%0d", i), seen[i].inst, exp_inst[i]);
      chk($sformatf("lit_addr%0d", i), seen[i].addr,
          BASE + 32'(4 * i));
    end

    // Fill to full, then LI stalls in SECOND until one pop
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(3'd2, 6'h0D, 6'd0, 5'd0, 5'(i), 5'd0, 5'd0, 32'(i));
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'd4, 6'd0, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain("drain_full");

    // Reset while waiting to emit the trailing ORI
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++)
      send(3'd5, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(3'd4, 6'd0, 6'd0, 5'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    seen.delete();
    out_ready = 1'b1;
    send(3'd5, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    drain("drain_after_rst");
    chk("after_rst_words", seen.size(), 1);
    if (seen.size() > 0) chk("after_rst_addr", seen[0].addr, BASE);

    // Random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          rnd_send();
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 40) == 0) out_ready = 1'b0;
        end
      end
    join
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Opposite direction of the decode side: turns a decoded instruction descriptor (kind, opcode, funct, register fields, immediate) into 32-bit MIPS machine words.
- Each word is tagged with a running fetch address and buffered in an output FIFO.
- Expands the LI pseudo-op into LUI/ORI pairs.
- Feeds instruction-ROM loaders and self-checking CPU benches through valid/ready on both sides.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, address tagged on the first word after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_kind  in  3  0 R, 1 SHIFT, 2 I, 3 J, 4 LI, 5 NOP; 6–7 illegal
- in_opcode  in  6  primary opcode (I/J kinds)
- in_funct  in  6  function field (R/SHIFT kinds)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  shift amount (SHIFT kind)
- in_imm  in  32  imm16 for I, target26 for J, full 32-bit constant for LI
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- out_inst  out  32  encoded word at FIFO head
- out_addr  out  32  address of that word
- err  out  1  one-cycle pulse on an illegal descriptor
- count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset values: FIFO empty, count=0, out_valid=0, err=0, next address=BASE_ADDR, FSM=IDLE.
- out_inst/out_addr are don't-care while out_valid=0.
- in_ready = (state==IDLE) && (count<DEPTH), registered-count based. A pop in the same cycle does not raise in_ready.
- Encodings, one FIFO push on the accept cycle; word visible on out_* the next cycle:
  - R: {000000, rs, rt, rd, 00000, funct}
  - SHIFT: {000000, 00000, rt, rd, shamt, funct}
  - I: {opcode, rs, rt, imm[15:0]}
  - J: {opcode, imm[25:0]}
  - NOP: 32'h0000_0000
- Legal R funct: AND, OR, XOR, NOR, ADDU, SLLV, SRLV, SRAV, JR, SYNC, MOVZ, MOVN, MFHI, MTHI, MFLO, MTLO.
- Legal SHIFT funct: SLL, SRL, SRA.
- Legal I opcode: ANDI, ORI, XORI, LUI, ADDIU, BEQ, BNE, BGTZ, PREF.
- Legal J opcode: J, JAL.
- Illegal descriptor (illegal kind, or funct/opcode outside its legal set):
  - Still accepted.
  - No push, address unchanged.
  - err=1 on the following cycle.
- LI handling, with hi=imm[31:16], lo=imm[15:0]:
  - hi==0: a single ORI rt,$0,lo = {001101, 00000, rt, lo}.
  - lo==0 and hi!=0: a single LUI rt,hi = {001111, 00000, rt, hi}.
  - Otherwise: push LUI on the accept cycle and go to SECOND. rt and lo are latched at accept.
- SECOND state:
  - Push ORI rt,rt,lo = {001101, rt, rt, lo} when count<DEPTH, then return to IDLE.
  - Stall in SECOND while the FIFO is full.
  - in_ready=0 for the whole of SECOND.
- Addresses:
  - Each pushed word takes the current address; the address then increments by 4.
  - Wraps modulo 2^32 (32'hFFFF_FFFC is followed by 0).
- FIFO:
  - Simultaneous push and pop leaves count unchanged and order is preserved.
  - Pop with out_valid=0 is ignored.
  - Head is stable while out_valid && !out_ready.
- rst mid-operation (including in SECOND): FIFO flushed, pending ORI discarded, address back to BASE_ADDR, no err pulse.

Test Plan:
- ORI $1,$0,0x1234 (kind 2, opcode 001101, rs 0, rt 1, imm 0x1234), out_ready=1 → next cycle out_inst=0x34011234, out_addr=0x0, count 1→0.
- LI $2,0x12345678 → 0x3C021234 @0x0, then 0x34425678 @0x4; in_ready low exactly 1 cycle. LI $2,0x00005678 → single 0x34025678. LI $2,0xABCD0000 → single 0x3C02ABCD.
- ADDU $3,$1,$2 → 0x00221821. SLL $4,$2,3 → 0x000220C0. J 0x100 → 0x08000100. NOP → 0x00000000. Addresses 0x0, 0x4, 0x8, 0xC.
- R kind funct 0x20 (ADD, unsupported) → accepted, err pulses 1 cycle, no push, next legal word still gets the previous address+4.
- out_ready=0 with DEPTH=4 and 4 pushes → count=4, in_ready=0, head stable. Then issue LI 0x12345678 with 3 entries queued → LUI pushed, FSM stalls in SECOND until a pop, then ORI pushed. Drained order is correct.
- BASE_ADDR=32'hFFFF_FFF8, three NOPs → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Assert rst while in SECOND → count=0, out_valid=0, next word tagged BASE_ADDR.
